// File: rtl/tlc_pkg.sv
// Shared traffic-light controller types: FSM state codes, phase classes
// and the duration clamp used by the phase timer.
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_RED,
        PH_GREEN_P,
        PH_GREEN_E,
        PH_YELLOW
    } phase_class_e;

    localparam int unsigned ST_ALL_RED    = 0;
    localparam int unsigned ST_A_GREEN_P  = 1;
    localparam int unsigned ST_A_GREEN_E  = 2;
    localparam int unsigned ST_A_YELLOW   = 3;
    localparam int unsigned ST_B_GREEN_P  = 4;
    localparam int unsigned ST_B_GREEN_E  = 5;
    localparam int unsigned ST_B_YELLOW   = 6;
    localparam int unsigned ST_C_GREEN_P  = 7;
    localparam int unsigned ST_C_GREEN_E  = 8;
    localparam int unsigned ST_C_YELLOW   = 9;
    localparam int unsigned ST_D_GREEN_P  = 10;
    localparam int unsigned ST_D_GREEN_E  = 11;
    localparam int unsigned ST_D_YELLOW   = 12;

    // Unknown codes fall back to RED so a corrupted state never yields green.
    function automatic phase_class_e state_to_class(input int unsigned code);
        phase_class_e cls;
        case (code)
            ST_A_GREEN_P, ST_B_GREEN_P, ST_C_GREEN_P, ST_D_GREEN_P: cls = PH_GREEN_P;
            ST_A_GREEN_E, ST_B_GREEN_E, ST_C_GREEN_E, ST_D_GREEN_E: cls = PH_GREEN_E;
            ST_A_YELLOW,  ST_B_YELLOW,  ST_C_YELLOW,  ST_D_YELLOW:  cls = PH_YELLOW;
            ST_ALL_RED:                                             cls = PH_RED;
            default:                                                cls = PH_RED;
        endcase
        return cls;
    endfunction

    function automatic int unsigned clamp_dur(input int unsigned v, input int unsigned max_v);
        int unsigned r;
        r = (v == 0) ? 1 : v;
        if (r > max_v) begin
            r = max_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_duration_lut.sv
// Combinational map from FSM state code to the phase duration, with
// zero durations clamped to one cycle and large ones saturated to CNT_W.
module phase_duration_lut
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W               = 8,
    parameter int unsigned STATE_W             = 4,
    parameter int unsigned RED_TIME            = 1,
    parameter int unsigned PRIMARY_GREEN_TIME  = 20,
    parameter int unsigned EXTENDED_GREEN_TIME = 30,
    parameter int unsigned YELLOW_TIME         = 5
) (
    input  logic [STATE_W-1:0] state_i,
    output logic [CNT_W-1:0]   dur_o
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    localparam logic [CNT_W-1:0] D_RED     = CNT_W'(clamp_dur(RED_TIME, CNT_MAX));
    localparam logic [CNT_W-1:0] D_GREEN_P = CNT_W'(clamp_dur(PRIMARY_GREEN_TIME, CNT_MAX));
    localparam logic [CNT_W-1:0] D_GREEN_E = CNT_W'(clamp_dur(EXTENDED_GREEN_TIME, CNT_MAX));
    localparam logic [CNT_W-1:0] D_YELLOW  = CNT_W'(clamp_dur(YELLOW_TIME, CNT_MAX));

    always_comb begin
        dur_o = D_RED;
        case (state_to_class(32'(state_i)))
            PH_GREEN_P: dur_o = D_GREEN_P;
            PH_GREEN_E: dur_o = D_GREEN_E;
            PH_YELLOW:  dur_o = D_YELLOW;
            default:    dur_o = D_RED;
        endcase
    end

endmodule

// File: rtl/phase_timer.sv
// Phase-duration timer: reloads on every FSM state change, counts down with
// hold and bounded green extension, and pulses expired at the end of a phase.
module phase_timer
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W               = 8,
    parameter int unsigned STATE_W             = 4,
    parameter int unsigned RED_TIME            = 1,
    parameter int unsigned PRIMARY_GREEN_TIME  = 20,
    parameter int unsigned EXTENDED_GREEN_TIME = 30,
    parameter int unsigned YELLOW_TIME         = 5,
    parameter int unsigned EXTEND_TIME         = 5,
    parameter int unsigned MAX_EXTEND          = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state,
    input  logic               hold,
    input  logic               extend_req,
    output logic               expired,
    output logic [CNT_W-1:0]   remaining,
    output logic               busy,
    output logic               ext_ack
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;
    localparam int unsigned EXT_W   = (MAX_EXTEND == 0) ? 1 : $clog2(MAX_EXTEND + 1);

    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [EXT_W-1:0]   ext_cnt_q, ext_cnt_d;
    logic [STATE_W-1:0] prev_state_q, prev_state_d;
    logic               armed_q, armed_d;
    logic               expired_q, expired_d;
    logic               ext_ack_q, ext_ack_d;

    logic [CNT_W-1:0]   dur;
    phase_class_e       cls;
    logic               load, counting, is_green, ext_ok;
    logic [31:0]        ext_sum;

    phase_duration_lut #(
        .CNT_W               (CNT_W),
        .STATE_W             (STATE_W),
        .RED_TIME            (RED_TIME),
        .PRIMARY_GREEN_TIME  (PRIMARY_GREEN_TIME),
        .EXTENDED_GREEN_TIME (EXTENDED_GREEN_TIME),
        .YELLOW_TIME         (YELLOW_TIME)
    ) u_lut (
        .state_i (state),
        .dur_o   (dur)
    );

    always_comb begin
        cls      = state_to_class(32'(state));
        is_green = (cls == PH_GREEN_P) || (cls == PH_GREEN_E);
        load     = !armed_q || (state != prev_state_q);
        counting = (remaining_q != '0) && !hold;
        ext_ok   = !load && is_green && (remaining_q != '0) && extend_req
                   && (32'(ext_cnt_q) < MAX_EXTEND);
        // An accepted extension absorbs this cycle's decrement, so a request
        // on the terminal cycle keeps the phase alive instead of expiring.
        ext_sum  = 32'(remaining_q) + EXTEND_TIME - (counting ? 32'd1 : 32'd0);

        remaining_d  = remaining_q;
        ext_cnt_d    = ext_cnt_q;
        prev_state_d = prev_state_q;
        armed_d      = armed_q;
        expired_d    = 1'b0;
        ext_ack_d    = 1'b0;

        if (load) begin
            remaining_d  = dur;
            ext_cnt_d    = '0;
            armed_d      = 1'b1;
            prev_state_d = state;
        end else if (ext_ok) begin
            remaining_d = (ext_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(ext_sum);
            ext_cnt_d   = ext_cnt_q + EXT_W'(1);
            ext_ack_d   = 1'b1;
        end else if (counting) begin
            remaining_d = remaining_q - CNT_W'(1);
            expired_d   = (remaining_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q  <= '0;
            ext_cnt_q    <= '0;
            prev_state_q <= '0;
            armed_q      <= 1'b0;
            expired_q    <= 1'b0;
            ext_ack_q    <= 1'b0;
        end else begin
            remaining_q  <= remaining_d;
            ext_cnt_q    <= ext_cnt_d;
            prev_state_q <= prev_state_d;
            armed_q      <= armed_d;
            expired_q    <= expired_d;
            ext_ack_q    <= ext_ack_d;
        end
    end

    assign remaining = remaining_q;
    assign expired   = expired_q;
    assign ext_ack   = ext_ack_q;
    assign busy      = (remaining_q != '0);

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: scenario table with an expiry
// scoreboard, plus hand-written reload, saturation and reset sequences.
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       rst, hold, extend_req;
    logic [3:0] state;
    logic       expired, busy, ext_ack;
    logic [7:0] remaining;

    logic       rst2, hold2, extend_req2;
    logic [3:0] state2;
    logic       expired2, busy2, ext_ack2;
    logic [4:0] remaining2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    phase_timer u_dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .hold       (hold),
        .extend_req (extend_req),
        .expired    (expired),
        .remaining  (remaining),
        .busy       (busy),
        .ext_ack    (ext_ack)
    );

    phase_timer #(.CNT_W(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst2),
        .state      (state2),
        .hold       (hold2),
        .extend_req (extend_req2),
        .expired    (expired2),
        .remaining  (remaining2),
        .busy       (busy2),
        .ext_ack    (ext_ack2)
    );

    // Mask bit k drives the input during the cycle before edge k after the load edge.
    typedef struct {
        logic [3:0]  st;
        logic [63:0] hold_mask;
        logic [63:0] ext_mask;
        int          exp_load;
        int          exp_expire;
        int          exp_acks;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];
    int   sb[$];

    initial begin
        int acks, nexp, k, e;

        vecs[0] = '{4'd1,  64'h0,  64'h0,         20, 20, 0};
        vecs[1] = '{4'd3,  64'h3C, 64'h0,         5,  9,  0};
        vecs[2] = '{4'd2,  64'h0,  64'h248,       30, 40, 2};
        vecs[3] = '{4'd3,  64'h0,  64'h6,         5,  5,  0};
        vecs[4] = '{4'd7,  64'h10, 64'h10,        20, 26, 1};
        vecs[5] = '{4'd0,  64'h0,  64'h0,         1,  1,  0};
        vecs[6] = '{4'd13, 64'h0,  64'h2,         1,  1,  0};
        vecs[7] = '{4'd8,  64'h0,  64'h4000_0000, 30, 35, 1};
        vecs[8] = '{4'd6,  64'h60, 64'h0,         5,  7,  0};

        rst = 1'b1; state = 4'd0; hold = 1'b0; extend_req = 1'b0;
        rst2 = 1'b1; state2 = 4'd0; hold2 = 1'b0; extend_req2 = 1'b0;
        step();
        step();
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_expired", int'(expired), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ext_ack", int'(ext_ack), 0);
        chk("rst_remaining5", int'(remaining2), 0);

        for (int i = 0; i < 9; i++) begin
            rst = 1'b1; state = vecs[i].st; hold = 1'b0; extend_req = 1'b0;
            step();
            step();
            rst = 1'b0;
            step();
            chk($sformatf("v%0d_load", i), int'(remaining), vecs[i].exp_load);
            chk($sformatf("v%0d_busy_load", i), int'(busy), 1);
            sb.push_back(vecs[i].exp_expire);
            acks = 0;
            nexp = 0;
            for (int c = 1; c < 60; c++) begin
                hold       = vecs[i].hold_mask[c];
                extend_req = vecs[i].ext_mask[c];
                step();
                if (ext_ack) acks++;
                if (expired) begin
                    nexp++;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk($sformatf("v%0d_expire_edge", i), c, e);
                        chk($sformatf("v%0d_busy_at_expire", i), int'(busy), 0);
                    end
                end
            end
            hold = 1'b0; extend_req = 1'b0;
            chk($sformatf("v%0d_expired_pulses", i), nexp, 1);
            chk($sformatf("v%0d_ack_count", i), acks, vecs[i].exp_acks);
            chk($sformatf("v%0d_pending", i), sb.size(), 0);
            sb.delete();
        end

        // State change on the terminal cycle reloads and suppresses expiry.
        rst = 1'b1; state = 4'd1;
        step();
        rst = 1'b0;
        step();
        k = 0;
        for (int c = 1; c < 40; c++) begin
            step();
            if (remaining == 8'd1) begin
                k = c;
                break;
            end
        end
        chk("chg_terminal_edge", k, 19);
        state = 4'd4;
        step();
        chk("chg_expired", int'(expired), 0);
        chk("chg_reload", int'(remaining), 20);
        step();
        chk("chg_count", int'(remaining), 19);

        // CNT_W=5 instance: extension saturates at 31, then reset mid-count.
        state2 = 4'd2;
        step();
        rst2 = 1'b0;
        step();
        chk("w5_load", int'(remaining2), 30);
        step();
        step();
        chk("w5_pre_ext", int'(remaining2), 28);
        extend_req2 = 1'b1;
        step();
        extend_req2 = 1'b0;
        chk("w5_saturate", int'(remaining2), 31);
        chk("w5_ext_ack", int'(ext_ack2), 1);
        step();
        chk("w5_ack_single", int'(ext_ack2), 0);
        chk("w5_count", int'(remaining2), 30);
        rst2 = 1'b1;
        step();
        chk("w5_rst_remaining", int'(remaining2), 0);
        chk("w5_rst_busy", int'(busy2), 0);
        rst2 = 1'b0;
        step();
        chk("w5_reload", int'(remaining2), 30);
        chk("w5_busy_reload", int'(busy2), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
